// File: rtl/counter_sequence_checker.sv
// Receive-side checker for the 3-bit binary/Gray counter: decodes each sample to a sequence index,
// checks step continuity and parity, and reports lock state plus a saturating error count.
module counter_sequence_checker #(
    parameter int LOCK_COUNT    = 4,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    input  logic                     i_control,
    input  logic [2:0]               i_code,
    input  logic                     i_flag,
    output logic [2:0]               o_decoded,
    output logic                     o_seq_error,
    output logic                     o_parity_error,
    output logic                     o_locked,
    output logic [ERR_CNT_WIDTH-1:0] o_error_count
);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ACQUIRE,
        ST_LOCKED
    } state_t;

    localparam logic [3:0] LOCK_TARGET = 4'(LOCK_COUNT);

    state_t     r_state;
    logic [2:0] r_idx;
    logic       r_mode;
    logic [3:0] r_good;

    logic [2:0] w_idx;
    logic [2:0] w_idx_expected;
    logic [3:0] w_good_next;
    logic       w_parity_bad;
    logic       w_resync;
    logic       w_step_bad;
    logic       w_err;

    // Gray-to-binary: each index bit is the XOR of all code bits at or above it.
    always_comb begin
        w_idx = i_code;
        if (i_control) begin
            w_idx[2] = i_code[2];
            w_idx[1] = i_code[2] ^ i_code[1];
            w_idx[0] = i_code[2] ^ i_code[1] ^ i_code[0];
        end
    end

    assign w_idx_expected = r_idx + 3'd1;
    assign w_good_next    = r_good + 4'd1;
    assign w_parity_bad   = i_flag != (^i_code);
    assign w_resync       = (r_state != ST_EMPTY) && (i_control != r_mode);
    assign w_step_bad     = (r_state != ST_EMPTY) && !w_resync && (w_idx != w_idx_expected);
    assign w_err          = w_step_bad || w_parity_bad;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= ST_EMPTY;
            r_idx          <= 3'd0;
            r_mode         <= 1'b0;
            r_good         <= 4'd0;
            o_decoded      <= 3'd0;
            o_seq_error    <= 1'b0;
            o_parity_error <= 1'b0;
            o_locked       <= 1'b0;
            o_error_count  <= '0;
        end else begin
            o_seq_error    <= 1'b0;
            o_parity_error <= 1'b0;
            if (i_valid) begin
                r_idx          <= w_idx;
                r_mode         <= i_control;
                o_decoded      <= w_idx;
                o_seq_error    <= w_step_bad;
                o_parity_error <= w_parity_bad;
                if (w_err && (o_error_count != '1)) begin
                    o_error_count <= o_error_count + ERR_CNT_WIDTH'(1);
                end
                // First sample, mode change and any error all restart acquisition.
                if ((r_state == ST_EMPTY) || w_resync || w_err) begin
                    r_state  <= ST_ACQUIRE;
                    r_good   <= 4'd0;
                    o_locked <= 1'b0;
                end else if (r_state == ST_ACQUIRE) begin
                    r_good <= w_good_next;
                    if (w_good_next == LOCK_TARGET) begin
                        r_state  <= ST_LOCKED;
                        o_locked <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: doc/counter_sequence_checker.md
Name: counter_sequence_checker

Overview:
- Receive side for the 3-bit binary/Gray code counter: samples its Code/Flag/Control outputs.
- Decodes each code to a sequence index; checks step-by-step sequence continuity and XOR parity.
- Reports lock status and errors to the board-level status logic.
- Per-sample path, registered outputs, single clock domain.

Parameters:
- LOCK_COUNT, 4, consecutive good transitions needed to assert Locked (legal range 1..15).
- ERR_CNT_WIDTH, 8, width of the saturating error counter.

Ports:
- Clock  input  1  rising-edge system clock.
- Reset  input  1  asynchronous, active-high reset.
- Valid  input  1  Code/Flag/Control are sampled on a rising edge when Valid=1.
- Control  input  1  0 = binary count sequence, 1 = Gray count sequence.
- Code  input  3  counter value under test.
- Flag  input  1  received parity; must equal Code[2]^Code[1]^Code[0].
- Decoded  output  3  sequence index of the last accepted sample.
- SeqError  output  1  one-cycle pulse: sequence discontinuity.
- ParityError  output  1  one-cycle pulse: Flag mismatch.
- Locked  output  1  LOCK_COUNT consecutive good transitions seen since the last error or resync.
- ErrorCount  output  ERR_CNT_WIDTH  saturating count of erroneous samples.

Behaviour:
- Reset (async, active-high) forces:
  - Decoded=0, SeqError=0, ParityError=0, Locked=0, ErrorCount=0.
  - State=EMPTY; good counter=0; stored index/mode=0.
  - Reset mid-stream discards all history.
- Index decode:
  - Control=0: idx=Code.
  - Control=1: Gray-to-binary, i.e. idx[2]=Code[2], idx[1]=Code[2]^Code[1], idx[0]=idx[1]^Code[0].
  - Gray order 0,1,3,2,6,7,5,4 therefore maps to idx 0..7.
- Expected step: idx == prev_idx+1 mod 8 in both modes; 7->0 wrap is legal.
- Outputs are registered; the response appears on the edge that samples Valid=1 (visible the following cycle).
- Valid=0: no state change; SeqError and ParityError return to 0; Decoded, Locked and ErrorCount hold.
- Parity check: ParityError=1 when Flag != ^Code. The check applies in every state, including EMPTY.
- States:
  - EMPTY (no previous sample):
    - On Valid: store idx and Control, Decoded=idx, go to ACQUIRE, good counter=0.
    - SeqError is never raised from EMPTY.
  - ACQUIRE:
    - On Valid with the same Control as the stored mode:
      - Good sample (correct step and correct parity): good counter+1; when it reaches LOCK_COUNT, go to LOCKED with Locked=1 on the same edge.
      - Wrong step: SeqError=1.
      - Either error: good counter=0, stay in ACQUIRE.
  - LOCKED:
    - On Valid: good sample stays in LOCKED.
    - Any error: SeqError and/or ParityError as applicable, Locked=0, go to ACQUIRE, good counter=0.
- Mode change: Valid with Control != stored mode is a resync.
  - No sequence check and no SeqError.
  - Parity is still checked.
  - Go to ACQUIRE, good counter=0, Locked=0.
- Every Valid sample updates the stored idx, stored mode and Decoded, even erroneous ones. The next step is checked relative to the sample just received.
- ErrorCount:
  - +1 per sample with SeqError or ParityError (+1 only, even if both are set).
  - Saturates at all-ones and never wraps.

Test Plan:
- Binary run: Control=0, Code 0..7,0,1 with correct Flag, LOCK_COUNT=4 -> Locked rises with the 5th sample (Code=4); Decoded tracks 0..7,0,1; no error pulses; ErrorCount=0.
- Gray run: Control=1, Code 0,1,3,2,6,7,5,4,0 -> Decoded 0,1,2,3,4,5,6,7,0; Locked=1 from the 5th sample; no errors.
- Skip: locked Gray stream 1,3,6,7 -> SeqError pulse on 6 (expected idx 3, got 4); Locked drops; ErrorCount=1; 7 counts as good (good counter=1).
- Parity: locked binary Code=3 with Flag=1 -> ParityError=1 only, SeqError=0, Locked=0, ErrorCount+1.
- Mode switch with gaps: binary 2,3, then Control=1 Code=5, Valid low 3 cycles, Code=4 -> no SeqError at the switch or over the gap; good counter=1 after Code=4.
- Saturation/reset: ERR_CNT_WIDTH=2, 5 errors -> ErrorCount=3 and holds; Reset asserted mid-cycle -> all outputs 0 immediately, next sample re-enters via EMPTY with no SeqError.
